spi_master_ctrl: RTL

Host-side SPI master that sequences command frames into the SPI slave / single-port RAM subsystem. It accepts 10-bit command words (2-bit opcode + 8-bit payload) over a valid/ready handshake and serializes them MSB-first on MOSI under SS_n. For read-data commands it captures the 8-bit MISO response and returns it on rd_data. The block runs on the same clk as the slave; one bit moves per clk cycle. It is the stimulus source for system-level SPI-RAM runs and the front end for the host port.

---
 rtl/spi_master_ctrl_pkg.sv | 30 +++
 rtl/spi_master_ctrl_if.sv | 46 ++++
 rtl/spi_master_ctrl_shifter.sv | 54 +++++
 rtl/spi_master_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/spi_master_ctrl_pkg.sv
// Shared types and constants for the host-side SPI master controller.
// Imported by the interface, the shifter and the top-level controller.
package spi_master_ctrl_pkg;

  localparam int MEM_WIDTH = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_opcode_e;

  typedef enum logic [2:0] {
    M_IDLE    = 3'd0,
    M_START   = 3'd1,
    M_SHIFT   = 3'd2,
    M_TURN    = 3'd3,
    M_CAPTURE = 3'd4,
    M_GAP     = 3'd5
  } spi_mst_state_e;

  // Phase counters cover the longest phase: the command word or a 15-cycle turnaround/gap.
  function automatic int cnt_width(input int mem_width);
    int span;
    span = ((mem_width + 2) > 15) ? (mem_width + 2) : 15;
    return $clog2(span);
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Command/response handshake plus SPI pins of the master controller.
// The master modport is the controller; the slave modport is the host/slave side.
interface spi_master_ctrl_if #(
  parameter int MEM_WIDTH = spi_master_ctrl_pkg::MEM_WIDTH
) ();

  import spi_master_ctrl_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [MEM_WIDTH+1:0] cmd_data;
  logic                 rd_valid;
  logic [MEM_WIDTH-1:0] rd_data;
  logic                 rd_order_err;
  logic                 busy;
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;

  modport master (
    input  cmd_valid,
    input  cmd_data,
    input  MISO,
    output cmd_ready,
    output rd_valid,
    output rd_data,
    output rd_order_err,
    output busy,
    output SS_n,
    output MOSI
  );

  modport slave (
    output cmd_valid,
    output cmd_data,
    output MISO,
    input  cmd_ready,
    input  rd_valid,
    input  rd_data,
    input  rd_order_err,
    input  busy,
    input  SS_n,
    input  MOSI
  );

endinterface

// File: rtl/spi_master_ctrl_shifter.sv
// MOSI parallel-in/serial-out register and MISO serial-in/parallel-out register.
// MOSI is registered and forced low whenever the FSM is not shifting.
module spi_master_ctrl_shifter #(
  parameter int MEM_WIDTH = spi_master_ctrl_pkg::MEM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [MEM_WIDTH+1:0] i_load_data,
  input  logic                 i_tx_en,
  input  logic                 i_rx_en,
  input  logic                 i_miso,
  output logic                 o_mosi,
  output logic [MEM_WIDTH-1:0] o_rx_nxt
);

  import spi_master_ctrl_pkg::*;

  logic [MEM_WIDTH+1:0] r_tx;
  logic                 r_mosi;
  logic [MEM_WIDTH-1:0] r_rx;
  logic [MEM_WIDTH-1:0] w_rx_nxt;

  assign w_rx_nxt = {r_rx[MEM_WIDTH-2:0], i_miso};
  assign o_rx_nxt = w_rx_nxt;
  assign o_mosi   = r_mosi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx   <= {(MEM_WIDTH+2){1'b0}};
      r_mosi <= 1'b0;
    end else if (i_load) begin
      r_tx   <= i_load_data;
      r_mosi <= 1'b0;
    end else if (i_tx_en) begin
      r_mosi <= r_tx[MEM_WIDTH+1];
      r_tx   <= {r_tx[MEM_WIDTH:0], 1'b0};
    end else begin
      r_tx   <= r_tx;
      r_mosi <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx <= {MEM_WIDTH{1'b0}};
    end else if (i_rx_en) begin
      r_rx <= w_rx_nxt;
    end else begin
      r_rx <= r_rx;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: serializes opcode+payload command words MSB-first and,
// for RD_DATA frames, captures the slave's MISO byte after a turnaround window.
module spi_master_ctrl #(
  parameter int MEM_WIDTH  = spi_master_ctrl_pkg::MEM_WIDTH,
  parameter int TURNAROUND = 2,
  parameter int GAP        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_master_ctrl_if.master bus
);

  import spi_master_ctrl_pkg::*;

  localparam int            CW         = cnt_width(MEM_WIDTH);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(MEM_WIDTH + 1);
  localparam logic [CW-1:0] TURN_LAST  = CW'(TURNAROUND - 1);
  localparam logic [CW-1:0] CAP_LAST   = CW'(MEM_WIDTH - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  spi_mst_state_e       r_state;
  spi_mst_state_e       w_state_nxt;
  logic [CW-1:0]        r_cnt;
  spi_opcode_e          r_opcode;
  spi_opcode_e          w_cmd_op;
  logic                 r_rd_addr_pending;
  logic                 r_cmd_ready;
  logic                 r_busy;
  logic                 r_ss_n;
  logic                 r_rd_valid;
  logic                 r_rd_order_err;
  logic [MEM_WIDTH-1:0] r_rd_data;
  logic [MEM_WIDTH-1:0] w_rx_nxt;
  logic                 w_accept;
  logic                 w_ss_n_nxt;
  logic                 w_busy_nxt;
  logic                 w_cmd_ready_nxt;
  logic                 w_tx_en;
  logic                 w_rx_en;
  logic                 w_cap_done;
  logic                 w_mosi;

  assign w_cmd_op = spi_opcode_e'(bus.cmd_data[MEM_WIDTH+1:MEM_WIDTH]);
  assign w_accept = r_cmd_ready && bus.cmd_valid && (r_state == M_IDLE);

  // Phase counter restarts on every state entry, so no phase ever wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= M_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_opcode <= WR_ADDR;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || (r_state == M_IDLE)) begin
        r_cnt <= {CW{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_accept) begin
        r_opcode <= w_cmd_op;
      end else begin
        r_opcode <= r_opcode;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      M_IDLE: begin
        if (w_accept) w_state_nxt = M_START;
        else          w_state_nxt = M_IDLE;
      end
      M_START: w_state_nxt = M_SHIFT;
      M_SHIFT: begin
        if (r_cnt == SHIFT_LAST) w_state_nxt = (r_opcode == RD_DATA) ? M_TURN : M_GAP;
        else                     w_state_nxt = M_SHIFT;
      end
      M_TURN: begin
        if (r_cnt == TURN_LAST) w_state_nxt = M_CAPTURE;
        else                    w_state_nxt = M_TURN;
      end
      M_CAPTURE: begin
        if (r_cnt == CAP_LAST) w_state_nxt = M_GAP;
        else                   w_state_nxt = M_CAPTURE;
      end
      M_GAP: begin
        if (r_cnt == GAP_LAST) w_state_nxt = M_IDLE;
        else                   w_state_nxt = M_GAP;
      end
      default: w_state_nxt = M_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    w_ss_n_nxt = 1'b1;
    case (w_state_nxt)
      M_START, M_SHIFT, M_TURN, M_CAPTURE: w_ss_n_nxt = 1'b0;
      default:                             w_ss_n_nxt = 1'b1;
    endcase
    w_busy_nxt      = (w_state_nxt != M_IDLE);
    w_cmd_ready_nxt = (w_state_nxt == M_IDLE);
    w_tx_en         = (w_state_nxt == M_SHIFT);
    w_rx_en         = (r_state == M_CAPTURE);
    w_cap_done      = (r_state == M_CAPTURE) && (r_cnt == CAP_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= {MEM_WIDTH{1'b0}};
    end else begin
      r_ss_n      <= w_ss_n_nxt;
      r_busy      <= w_busy_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rd_valid  <= w_cap_done;
      if (w_cap_done) begin
        r_rd_data <= w_rx_nxt;
      end else begin
        r_rd_data <= r_rd_data;
      end
    end
  end

  // RD_DATA without an outstanding RD_ADDR is flagged but still executed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr_pending <= 1'b0;
      r_rd_order_err    <= 1'b0;
    end else begin
      r_rd_order_err <= w_accept && (w_cmd_op == RD_DATA) && !r_rd_addr_pending;
      if (w_accept && (w_cmd_op == RD_ADDR)) begin
        r_rd_addr_pending <= 1'b1;
      end else if (w_accept && (w_cmd_op == RD_DATA)) begin
        r_rd_addr_pending <= 1'b0;
      end else begin
        r_rd_addr_pending <= r_rd_addr_pending;
      end
    end
  end

  spi_master_ctrl_shifter #(
    .MEM_WIDTH (MEM_WIDTH)
  ) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_accept),
    .i_load_data (bus.cmd_data),
    .i_tx_en     (w_tx_en),
    .i_rx_en     (w_rx_en),
    .i_miso      (bus.MISO),
    .o_mosi      (w_mosi),
    .o_rx_nxt    (w_rx_nxt)
  );

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.busy         = r_busy;
  assign bus.SS_n         = r_ss_n;
  assign bus.MOSI         = w_mosi;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_order_err = r_rd_order_err;

endmodule
